pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_if.sv | 28 ++
 rtl/pc_fetch.sv | 88 ++++++++
 tb/tb_pc_fetch.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and
// instruction memory (slave).
`ifndef DATASIZE
`define DATASIZE 32
`endif

interface pc_fetch_if #(
    parameter int datawidth = `DATASIZE
);
    logic                 imem_req;
    logic [datawidth-1:0] imem_addr;
    logic                 imem_ack;
    logic [datawidth-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: IDLE/FETCH/HOLD control, PC register and a one-entry
// registered instruction slot toward decode, with branch redirect.
`ifndef DATASIZE
`define DATASIZE 32
`endif

module pc_fetch #(
    parameter int                   datawidth = `DATASIZE,
    parameter logic [datawidth-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [datawidth-1:0] br_target,
    input  logic [datawidth-1:0] npc_in,
    output logic [datawidth-1:0] pc_cur,
    pc_fetch_if.master           imem,
    output logic [datawidth-1:0] inst_out,
    output logic [datawidth-1:0] inst_pc,
    output logic                 inst_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    logic   req;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_cur;

    // NOTE: req is registered alongside the state so it is a clean flop output,
    // and every register here uses non-blocking assignment so all of them
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req        <= 1'b0;
            pc_cur     <= RESET_PC;
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (br_taken) begin
            // Redirect wins over any same-cycle ack; the returned word is dropped.
            state      <= IDLE;
            req        <= 1'b0;
            pc_cur     <= br_target;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req   <= 1'b1;
                end
                FETCH: begin
                    if (inst_valid && stall) begin
                        // Decode is full: drop the request, ignore any ack.
                        state <= HOLD;
                        req   <= 1'b0;
                    end else if (imem.imem_ack) begin
                        inst_out   <= imem.imem_data;
                        inst_pc    <= pc_cur;
                        inst_valid <= 1'b1;
                        pc_cur     <= npc_in;
                    end else begin
                        inst_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state      <= FETCH;
                        req        <= 1'b1;
                        inst_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, streaming, stall/hold, branch, delayed ack,
// PC wrap and mid-request reset, with hand-computed expectations.
`timescale 1ns/1ps

module tb_pc_fetch;
    localparam int            DW  = 32;
    localparam logic [DW-1:0] OFS = 32'h100;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          br_taken;
    logic [DW-1:0] br_target;
    logic [DW-1:0] npc_in;
    logic [DW-1:0] pc_cur;
    logic [DW-1:0] inst_out;
    logic [DW-1:0] inst_pc;
    logic          inst_valid;
    logic          ack;

    int vectors     = 0;
    int miscompares = 0;

    pc_fetch_if #(.datawidth(DW)) bus ();

    pc_fetch #(.datawidth(DW), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .npc_in     (npc_in),
        .pc_cur     (pc_cur),
        .imem       (bus.master),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid)
    );

    // Downstream adder and a memory whose word is address + 0x100.
    assign npc_in        = pc_cur + 1'b1;
    assign bus.imem_ack  = ack;
    assign bus.imem_data = bus.imem_addr + OFS;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [DW-1:0] pc,
                             input logic [DW-1:0] next_addr);
        check({tag, "_valid"}, DW'(inst_valid), DW'(v));
        check({tag, "_pc"},    inst_pc,         pc);
        check({tag, "_inst"},  inst_out,        pc + OFS);
        check({tag, "_addr"},  bus.imem_addr,   next_addr);
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        ack       = 1'b0;
        step();
        step();

        // Reset state
        check("rst_pc",    pc_cur,               32'h0);
        check("rst_req",   DW'(bus.imem_req),    32'h0);
        check("rst_valid", DW'(inst_valid),      32'h0);
        check("rst_inst",  inst_out,             32'h0);
        check("rst_ipc",   inst_pc,              32'h0);

        // Release with ack already high: IDLE cycle ignores it
        rst = 1'b0;
        ack = 1'b1;
        #1;
        check("idle_req", DW'(bus.imem_req), 32'h0);
        step();
        check("first_req",   DW'(bus.imem_req), 32'h1);
        check("first_addr",  bus.imem_addr,     32'h0);
        check("first_valid", DW'(inst_valid),   32'h0);

        // Streaming, one instruction per cycle
        step(); check_out("s0", 1'b1, 32'h0, 32'h1);
        step(); check_out("s1", 1'b1, 32'h1, 32'h2);
        step(); check_out("s2", 1'b1, 32'h2, 32'h3);

        // Stall three cycles while inst_pc = 2
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("hold", 1'b1, 32'h2, 32'h3);
            check("hold_req", DW'(bus.imem_req), 32'h0);
        end
        stall = 1'b0;
        step();
        check("unhold_valid", DW'(inst_valid),   32'h0);
        check("unhold_req",   DW'(bus.imem_req), 32'h1);
        check("unhold_addr",  bus.imem_addr,     32'h3);
        step(); check_out("s3", 1'b1, 32'h3, 32'h4);
        step(); check_out("s4", 1'b1, 32'h4, 32'h5);

        // Branch coinciding with the ack of pc 5
        br_taken  = 1'b1;
        br_target = 32'h40;
        step();
        br_taken = 1'b0;
        check("br_valid", DW'(inst_valid),   32'h0);
        check("br_pc",    pc_cur,            32'h40);
        check("br_req",   DW'(bus.imem_req), 32'h0);
        step();
        check("br_idle_valid", DW'(inst_valid),   32'h0);
        check("br_fetch_req",  DW'(bus.imem_req), 32'h1);
        step(); check_out("br_tgt", 1'b1, 32'h40, 32'h41);

        // Ack delayed two cycles
        ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("dly_valid", DW'(inst_valid),   32'h0);
            check("dly_req",   DW'(bus.imem_req), 32'h1);
            check("dly_addr",  bus.imem_addr,     32'h41);
        end
        ack = 1'b1;
        step(); check_out("dly_ack", 1'b1, 32'h41, 32'h42);

        // PC wrap through the adder
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFF;
        step();
        br_taken = 1'b0;
        step();
        check("wrap_req_addr", bus.imem_addr, 32'hFFFF_FFFF);
        step();
        check("wrap_pc",   inst_pc,       32'hFFFF_FFFF);
        check("wrap_inst", inst_out,      32'h0000_00FF);
        check("wrap_addr", bus.imem_addr, 32'h0);
        for (int i = 0; i < 7; i++) step();
        check("pre_rst_addr", bus.imem_addr,     32'h7);
        check("pre_rst_req",  DW'(bus.imem_req), 32'h1);

        // Reset pulsed mid-request at pc 7
        rst = 1'b1;
        #1;
        check("arst_pc",    pc_cur,            32'h0);
        check("arst_req",   DW'(bus.imem_req), 32'h0);
        check("arst_valid", DW'(inst_valid),   32'h0);
        check("arst_inst",  inst_out,          32'h0);
        check("arst_ipc",   inst_pc,           32'h0);
        step();
        rst = 1'b0;
        #1;
        check("rel_req", DW'(bus.imem_req), 32'h0);
        step();
        check("refetch_req",  DW'(bus.imem_req), 32'h1);
        check("refetch_addr", bus.imem_addr,     32'h0);
        step(); check_out("refetch", 1'b1, 32'h0, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
